// File: rtl/snax_alu_ctrl.sv
// -----------------------------------------------------------------------------
// snax_alu_ctrl : job sequencer gating one SNAX ALU PE (optional SNAX_ALU_CTRL_PERF_EN)
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module snax_alu_ctrl #(
  parameter int unsigned LenWidth  = 16,
  parameter int unsigned PerfWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 csr_start_i,
  input  logic                 csr_abort_i,
  input  logic [LenWidth-1:0]  csr_len_i,
  input  logic [1:0]           csr_alu_config_i,
  output logic                 csr_busy_o,
  output logic                 csr_done_o,
  output logic [LenWidth-1:0]  csr_in_cnt_o,
  output logic [LenWidth-1:0]  csr_out_cnt_o,
  input  logic                 pe_in_fire_i,
  input  logic                 pe_c_valid_i,
  input  logic                 pe_c_ready_i,
  output logic                 pe_acc_ready_o,
  output logic [1:0]           pe_alu_config_o,
  output logic [PerfWidth-1:0] perf_cycles_o,
  output logic [PerfWidth-1:0] perf_stall_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [LenWidth-1:0] len_q, len_d;
  logic [LenWidth-1:0] in_cnt_q, in_cnt_d;
  logic [LenWidth-1:0] out_cnt_q, out_cnt_d;
  logic [1:0]          op_q, op_d;

  logic in_left;
  logic out_fire;
  logic acc_ready;
  logic start_acc;

  assign in_left   = (in_cnt_q != len_q);
  assign out_fire  = pe_c_valid_i & pe_c_ready_i;
  assign start_acc = (state_q == IDLE) & csr_start_i;

  // The PE holds one result; only load a new operand if that slot is free or draining now.
  assign acc_ready = (state_q == BUSY) & ~csr_abort_i & in_left
                   & (~pe_c_valid_i | pe_c_ready_i);

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    op_d      = op_q;
    unique case (state_q)
      IDLE: begin
        if (csr_start_i) begin
          in_cnt_d  = '0;
          out_cnt_d = '0;
          if (csr_len_i != '0) begin
            len_d   = csr_len_i;
            op_d    = csr_alu_config_i;
            state_d = BUSY;
          end else begin
            state_d = DONE;
          end
        end
      end
      BUSY: begin
        if (csr_abort_i) begin
          state_d = IDLE;
        end else begin
          if (pe_in_fire_i && in_left) begin
            in_cnt_d = in_cnt_q + LenWidth'(1);
          end
          if (out_fire) begin
            out_cnt_d = out_cnt_q + LenWidth'(1);
            if (out_cnt_d == len_q) begin
              state_d = DONE;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      len_q     <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      op_q      <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      op_q      <= op_d;
    end
  end

  assign csr_busy_o      = (state_q == BUSY);
  assign csr_done_o      = (state_q == DONE);
  assign csr_in_cnt_o    = in_cnt_q;
  assign csr_out_cnt_o   = out_cnt_q;
  assign pe_acc_ready_o  = acc_ready;
  assign pe_alu_config_o = op_q;

`ifdef SNAX_ALU_CTRL_PERF_EN
  logic [PerfWidth-1:0] cycles_q, cycles_d;
  logic [PerfWidth-1:0] stall_q, stall_d;

  always_comb begin
    cycles_d = cycles_q;
    stall_d  = stall_q;
    if (start_acc) begin
      cycles_d = '0;
      stall_d  = '0;
    end else if (state_q == BUSY) begin
      if (~&cycles_q) begin
        cycles_d = cycles_q + PerfWidth'(1);
      end
      if (in_left && !acc_ready && (~&stall_q)) begin
        stall_d = stall_q + PerfWidth'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cycles_q <= '0;
      stall_q  <= '0;
    end else begin
      cycles_q <= cycles_d;
      stall_q  <= stall_d;
    end
  end

  assign perf_cycles_o = cycles_q;
  assign perf_stall_o  = stall_q;
`else
  logic unused_start;
  assign unused_start  = start_acc;
  assign perf_cycles_o = '0;
  assign perf_stall_o  = '0;
`endif

  // A PE firing after all operands are loaded would overwrite an unconsumed result.
  property p_no_fire_when_full;
    @(posedge clk_i) disable iff (!rst_ni)
      (state_q == BUSY && pe_in_fire_i) |-> in_left;
  endproperty
  a_no_fire_when_full: assert property (p_no_fire_when_full);

endmodule

`default_nettype wire

// File: tb/tb_snax_alu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_snax_alu_ctrl : directed job table plus randomized stimulus against a job-level model
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_snax_alu_ctrl;

  localparam int LW = 16;
  localparam int PW = 32;
`ifdef SNAX_ALU_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          csr_start_i;
  logic          csr_abort_i;
  logic [LW-1:0] csr_len_i;
  logic [1:0]    csr_alu_config_i;
  logic          csr_busy_o;
  logic          csr_done_o;
  logic [LW-1:0] csr_in_cnt_o;
  logic [LW-1:0] csr_out_cnt_o;
  logic          pe_in_fire_i;
  logic          pe_c_valid_i;
  logic          pe_c_ready_i;
  logic          pe_acc_ready_o;
  logic [1:0]    pe_alu_config_o;
  logic [PW-1:0] perf_cycles_o;
  logic [PW-1:0] perf_stall_o;

  always #5 clk_i = ~clk_i;

  snax_alu_ctrl #(.LenWidth(LW), .PerfWidth(PW)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .csr_start_i      (csr_start_i),
    .csr_abort_i      (csr_abort_i),
    .csr_len_i        (csr_len_i),
    .csr_alu_config_i (csr_alu_config_i),
    .csr_busy_o       (csr_busy_o),
    .csr_done_o       (csr_done_o),
    .csr_in_cnt_o     (csr_in_cnt_o),
    .csr_out_cnt_o    (csr_out_cnt_o),
    .pe_in_fire_i     (pe_in_fire_i),
    .pe_c_valid_i     (pe_c_valid_i),
    .pe_c_ready_i     (pe_c_ready_i),
    .pe_acc_ready_o   (pe_acc_ready_o),
    .pe_alu_config_o  (pe_alu_config_o),
    .perf_cycles_o    (perf_cycles_o),
    .perf_stall_o     (perf_stall_o)
  );

  int checks   = 0;
  int failures = 0;

  // job-level reference: phase 0 idle, 1 running, 2 completion pulse
  int          m_state, m_len, m_in, m_out, m_op;
  logic [63:0] m_cyc, m_stall;
  bit          pe_slot;
  bit          want_in;
  int          job_fires;
  bit          last_busy, last_done;

  typedef struct {
    int len; int op; int hold; int abort_after; bit noise;
    int exp_in; int exp_out; bit exp_done; int exp_busy; int exp_stall;
  } job_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_len = 0; m_in = 0; m_out = 0; m_op = 0;
    m_cyc = 64'd0; m_stall = 64'd0;
    pe_slot = 1'b0;
  endtask

  task automatic check_outputs(input bit exp_acc);
    check("acc_ready",   64'(pe_acc_ready_o),  64'(exp_acc));
    check("busy",        64'(csr_busy_o),      64'(m_state == 1));
    check("done",        64'(csr_done_o),      64'(m_state == 2));
    check("in_cnt",      64'(csr_in_cnt_o),    64'(m_in));
    check("out_cnt",     64'(csr_out_cnt_o),   64'(m_out));
    check("alu_config",  64'(pe_alu_config_o), 64'(m_op));
    check("perf_cycles", 64'(perf_cycles_o),   PERF ? m_cyc : 64'd0);
    check("perf_stall",  64'(perf_stall_o),    PERF ? m_stall : 64'd0);
  endtask

  // One clock: entered and left just after a falling edge, inputs already driven.
  task automatic step();
    bit exp_acc, fire, ofire;
    pe_c_valid_i = pe_slot;
    #1;
    exp_acc = (m_state == 1) && !csr_abort_i && (m_in < m_len) && (!pe_slot || pe_c_ready_i);
    fire = want_in && pe_acc_ready_o;
    pe_in_fire_i = fire;
    #1;
    check_outputs(exp_acc);
    last_busy = csr_busy_o;
    last_done = csr_done_o;
    ofire = pe_slot && pe_c_ready_i;
    if (fire) check("no_overwrite", 64'(pe_slot && !ofire), 64'd0);
    @(posedge clk_i);
    case (m_state)
      0: if (csr_start_i) begin
        m_in = 0; m_out = 0; m_cyc = 64'd0; m_stall = 64'd0;
        if (csr_len_i != '0) begin
          m_len = int'(csr_len_i); m_op = int'(csr_alu_config_i); m_state = 1;
        end else begin
          m_state = 2;
        end
      end
      1: begin
        if (m_cyc < 64'hFFFF_FFFF) m_cyc = m_cyc + 64'd1;
        if (m_in < m_len && !exp_acc) m_stall = m_stall + 64'd1;
        if (csr_abort_i) begin
          m_state = 0;
        end else begin
          if (fire) m_in++;
          if (ofire) m_out++;
          if (m_out == m_len) m_state = 2;
        end
      end
      default: m_state = 0;
    endcase
    if (ofire) pe_slot = 1'b0;
    if (fire) begin
      pe_slot = 1'b1;
      job_fires++;
    end
    @(negedge clk_i);
  endtask

  task automatic run_job(input job_t j, output int busy_n, output bit done_seen,
                         output int done_at);
    int  hold_left;
    bit  aborted, finished;
    hold_left = -1; aborted = 1'b0; finished = 1'b0;
    busy_n = 0; done_seen = 1'b0; done_at = -1; job_fires = 0;
    want_in = 1'b1;
    for (int n = 0; n < 300 && !finished; n++) begin
      csr_start_i = (n == 0) || (j.noise && n == 2);
      csr_len_i        = (j.noise && n == 2) ? LW'(9) : LW'(j.len);
      csr_alu_config_i = (j.noise && n == 2) ? 2'd1  : 2'(j.op);
      if (pe_slot && hold_left < 0) hold_left = j.hold;
      if (hold_left > 0) begin
        pe_c_ready_i = 1'b0;
        hold_left--;
      end else begin
        pe_c_ready_i = 1'b1;
      end
      csr_abort_i = (n > 0) && (j.abort_after > 0) && (job_fires == j.abort_after) && !aborted;
      if (csr_abort_i) aborted = 1'b1;
      step();
      if (last_busy) busy_n++;
      if (last_done) begin
        done_seen = 1'b1;
        done_at = n;
      end
      if (n > 0 && m_state == 0 && !pe_slot) finished = 1'b1;
    end
    check("job_finished", 64'(finished), 64'd1);
    csr_start_i = 1'b0; csr_abort_i = 1'b0; pe_c_ready_i = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    job_t jobs[7];
    int   busy_n, done_at;
    bit   done_seen, drained;

    jobs[0] = '{len: 4, op: 2, hold: 0, abort_after: 0, noise: 1'b0,
                exp_in: 4, exp_out: 4, exp_done: 1'b1, exp_busy: 5, exp_stall: 0};
    jobs[1] = '{len: 3, op: 1, hold: 3, abort_after: 0, noise: 1'b0,
                exp_in: 3, exp_out: 3, exp_done: 1'b1, exp_busy: 7, exp_stall: 3};
    jobs[2] = '{len: 0, op: 3, hold: 0, abort_after: 0, noise: 1'b0,
                exp_in: 0, exp_out: 0, exp_done: 1'b1, exp_busy: 0, exp_stall: 0};
    jobs[3] = '{len: 8, op: 0, hold: 0, abort_after: 3, noise: 1'b0,
                exp_in: 3, exp_out: 2, exp_done: 1'b0, exp_busy: 4, exp_stall: 1};
    jobs[4] = '{len: 5, op: 1, hold: 2, abort_after: 0, noise: 1'b0,
                exp_in: 5, exp_out: 5, exp_done: 1'b1, exp_busy: 8, exp_stall: 2};
    jobs[5] = '{len: 4, op: 0, hold: 0, abort_after: 0, noise: 1'b1,
                exp_in: 4, exp_out: 4, exp_done: 1'b1, exp_busy: 5, exp_stall: 0};
    jobs[6] = '{len: 1, op: 3, hold: 0, abort_after: 0, noise: 1'b0,
                exp_in: 1, exp_out: 1, exp_done: 1'b1, exp_busy: 2, exp_stall: 0};

    rst_ni = 1'b0;
    csr_start_i = 1'b0; csr_abort_i = 1'b0; csr_len_i = '0; csr_alu_config_i = 2'd0;
    pe_in_fire_i = 1'b0; pe_c_valid_i = 1'b0; pe_c_ready_i = 1'b1;
    want_in = 1'b1; job_fires = 0; last_busy = 1'b0; last_done = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_i);
    check_outputs(1'b0);
    rst_ni = 1'b1;
    repeat (5) step();

    for (int k = 0; k < 7; k++) begin
      run_job(jobs[k], busy_n, done_seen, done_at);
      check($sformatf("job%0d_in_cnt", k),  64'(csr_in_cnt_o),  64'(jobs[k].exp_in));
      check($sformatf("job%0d_out_cnt", k), 64'(csr_out_cnt_o), 64'(jobs[k].exp_out));
      check($sformatf("job%0d_done", k),    64'(done_seen),     64'(jobs[k].exp_done));
      check($sformatf("job%0d_busy_cycles", k), 64'(busy_n),    64'(jobs[k].exp_busy));
      if (jobs[k].exp_done)
        check($sformatf("job%0d_done_latency", k), 64'(done_at), 64'(jobs[k].exp_busy + 1));
      if (jobs[k].len != 0)
        check($sformatf("job%0d_config", k), 64'(pe_alu_config_o), 64'(jobs[k].op));
      check($sformatf("job%0d_perf_stall", k),  64'(perf_stall_o),
            PERF ? 64'(jobs[k].exp_stall) : 64'd0);
      check($sformatf("job%0d_perf_cycles", k), 64'(perf_cycles_o),
            PERF ? 64'(jobs[k].exp_busy) : 64'd0);
    end

    // reset in the middle of a job
    csr_start_i = 1'b1; csr_len_i = LW'(6); csr_alu_config_i = 2'd3;
    step();
    csr_start_i = 1'b0;
    repeat (3) step();
    #2;
    rst_ni = 1'b0;
    #1;
    check("midreset_busy",   64'(csr_busy_o),      64'd0);
    check("midreset_done",   64'(csr_done_o),      64'd0);
    check("midreset_in_cnt", 64'(csr_in_cnt_o),    64'd0);
    check("midreset_acc",    64'(pe_acc_ready_o),  64'd0);
    check("midreset_config", 64'(pe_alu_config_o), 64'd0);
    model_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (3) step();

    // randomized traffic, including aborts and starts in every state
    for (int i = 0; i < 800; i++) begin
      csr_start_i      = ($urandom_range(0, 5) == 0);
      csr_len_i        = LW'($urandom_range(0, 10));
      csr_alu_config_i = 2'($urandom_range(0, 3));
      csr_abort_i      = ($urandom_range(0, 24) == 0);
      pe_c_ready_i     = ($urandom_range(0, 3) != 0);
      want_in          = ($urandom_range(0, 7) != 0);
      step();
    end

    csr_start_i = 1'b0; csr_abort_i = 1'b0; pe_c_ready_i = 1'b1; want_in = 1'b1;
    drained = 1'b0;
    for (int i = 0; i < 100 && !drained; i++) begin
      step();
      if (m_state == 0 && !pe_slot) drained = 1'b1;
    end
    check("final_drain", 64'(drained), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
